// File: rtl/bp_be_fp_fflags_accum.sv
// FP exception-flag accumulator: buffers writeback flags until commit/flush, owns fflags/frm, resolves rm.
// Updates land the cycle after commit/CSR write; wb_ready_o drops when the pending FIFO is full. Macro: BP_BE_FFLAGS_BYPASS_EN.
module bp_be_fp_fflags_accum #(
  parameter int pending_els_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       wb_v_i,
  input  logic [4:0] wb_eflags_i,
  output logic       wb_ready_o,
  input  logic       commit_v_i,
  input  logic       flush_i,
  input  logic       csr_w_v_i,
  input  logic [1:0] csr_sel_i,
  input  logic [7:0] csr_data_i,
  output logic [7:0] csr_data_o,
  input  logic [2:0] instr_rm_i,
  output logic [2:0] rm_o,
  output logic       rm_illegal_o,
  output logic [4:0] fflags_o,
  output logic [2:0] frm_o,
  output logic       fs_dirty_o
);

  localparam int ptr_w_lp = $clog2(pending_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(pending_els_p);

  logic [4:0]          pend_mem_r [pending_els_p];
  logic [ptr_w_lp-1:0] head_r, tail_r;
  logic [cnt_w_lp-1:0] count_r;
  logic [4:0]          fflags_r;
  logic [2:0]          frm_r;
  logic                fs_dirty_r;

  logic       fifo_empty;
  logic       bypass;
  logic       push;
  logic       pop;
  logic [4:0] commit_flags;
  logic [4:0] fflags_or;
  logic [4:0] fflags_n;
  logic [2:0] frm_n;
  logic       csr_w_fflags;
  logic       csr_w_frm;
  logic       dirty_set;

  assign fifo_empty = (count_r == '0);
  assign wb_ready_o = (count_r < depth_lp);

`ifdef BP_BE_FFLAGS_BYPASS_EN
  // Writeback and commit of the same instruction with nothing queued: fold flags straight in.
  assign bypass = commit_v_i & wb_v_i & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push = wb_v_i & wb_ready_o & ~flush_i & ~bypass;
  assign pop  = commit_v_i & ~fifo_empty;

  always_comb begin
    commit_flags = '0;
    if (pop)
      commit_flags = pend_mem_r[head_r];
    else if (bypass)
      commit_flags = wb_eflags_i;
  end

  // CSR write owns any field it names; commit OR survives only in untouched fields.
  assign csr_w_fflags = csr_w_v_i & csr_sel_i[0];
  assign csr_w_frm    = csr_w_v_i & csr_sel_i[1];
  assign fflags_or    = fflags_r | commit_flags;
  assign fflags_n     = csr_w_fflags ? csr_data_i[4:0] : fflags_or;
  assign frm_n        = !csr_w_frm ? frm_r
                      : (csr_sel_i == 2'd3) ? csr_data_i[7:5] : csr_data_i[2:0];
  assign dirty_set    = (csr_w_v_i & (csr_sel_i != 2'd0)) | (fflags_or != fflags_r);

  always_ff @(posedge clk_i) begin
    if (push)
      pend_mem_r[tail_r] <= wb_eflags_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      fflags_r   <= '0;
      frm_r      <= '0;
      fs_dirty_r <= 1'b0;
    end else begin
      if (flush_i) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        head_r  <= head_r + (pop ? ptr_w_lp'(1) : '0);
        tail_r  <= tail_r + (push ? ptr_w_lp'(1) : '0);
        count_r <= count_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
      end
      fflags_r <= fflags_n;
      frm_r    <= frm_n;
      if (dirty_set)
        fs_dirty_r <= 1'b1;
    end
  end

  always_comb begin
    case (csr_sel_i)
      2'd1:    csr_data_o = {3'b000, fflags_r};
      2'd2:    csr_data_o = {5'b00000, frm_r};
      2'd3:    csr_data_o = {frm_r, fflags_r};
      default: csr_data_o = '0;
    endcase
  end

  assign rm_o         = (instr_rm_i == 3'b111) ? frm_r : instr_rm_i;
  assign rm_illegal_o = rm_o[2] & (rm_o[1] | rm_o[0]);
  assign fflags_o     = fflags_r;
  assign frm_o        = frm_r;
  assign fs_dirty_o   = fs_dirty_r;

`ifndef SYNTHESIS
  wb_while_full_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(wb_v_i && !wb_ready_o));
  commit_while_empty_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(commit_v_i && fifo_empty && !bypass));
`endif

endmodule

// File: tb/tb_bp_be_fp_fflags_accum.sv
// Scoreboard bench for bp_be_fp_fflags_accum: a queue-based flag model predicts post-edge state.
module tb_bp_be_fp_fflags_accum;
  localparam int depth = 4;
`ifdef BP_BE_FFLAGS_BYPASS_EN
  localparam bit bypass_en = 1'b1;
`else
  localparam bit bypass_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wb_v;
  logic [4:0] wb_eflags;
  logic       wb_ready;
  logic       commit_v;
  logic       flush;
  logic       csr_w_v;
  logic [1:0] csr_sel;
  logic [7:0] csr_wdata;
  logic [7:0] csr_rdata;
  logic [2:0] instr_rm;
  logic [2:0] rm;
  logic       rm_illegal;
  logic [4:0] fflags;
  logic [2:0] frm;
  logic       fs_dirty;

  always #5 clk = ~clk;

  bp_be_fp_fflags_accum #(.pending_els_p(depth)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .wb_v_i(wb_v), .wb_eflags_i(wb_eflags), .wb_ready_o(wb_ready),
    .commit_v_i(commit_v), .flush_i(flush),
    .csr_w_v_i(csr_w_v), .csr_sel_i(csr_sel), .csr_data_i(csr_wdata), .csr_data_o(csr_rdata),
    .instr_rm_i(instr_rm), .rm_o(rm), .rm_illegal_o(rm_illegal),
    .fflags_o(fflags), .frm_o(frm), .fs_dirty_o(fs_dirty)
  );

  typedef struct packed {
    logic [4:0] fflags;
    logic [2:0] frm;
    logic       ready;
    logic       dirty;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] pend_q[$];
  logic [4:0] m_fflags;
  logic [2:0] m_frm;
  logic       m_dirty;
  int         total = 0;
  int         bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic idle_inputs();
    wb_v = 1'b0; wb_eflags = '0; commit_v = 1'b0; flush = 1'b0;
    csr_w_v = 1'b0; csr_sel = '0; csr_wdata = '0; instr_rm = '0;
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    pend_q.delete(); exp_q.delete();
    m_fflags = '0; m_frm = '0; m_dirty = 1'b0;
    #2;
    check_eq({tag, ".fflags"}, 32'(fflags), 32'd0);
    check_eq({tag, ".frm"}, 32'(frm), 32'd0);
    check_eq({tag, ".ready"}, 32'(wb_ready), 32'd1);
    check_eq({tag, ".dirty"}, 32'(fs_dirty), 32'd0);
    reset_n = 1'b1;
  endtask

  // One clock of stimulus: model predicts, expectation is queued, then popped after the edge.
  task automatic step(input logic wv, input logic [4:0] wf, input logic cv, input logic fl,
                      input logic cw, input logic [1:0] sel, input logic [7:0] data,
                      input string tag);
    logic [4:0] cf;
    logic       byp;
    logic       rdy_pre;
    exp_t       e;
    wb_v = wv; wb_eflags = wf; commit_v = cv; flush = fl;
    csr_w_v = cw; csr_sel = sel; csr_wdata = data;
    rdy_pre = (pend_q.size() < depth);
    cf = '0; byp = 1'b0;
    if (cv && pend_q.size() > 0) cf = pend_q.pop_front();
    else if (cv && wv && bypass_en) begin cf = wf; byp = 1'b1; end
    if (wv && rdy_pre && !fl && !byp) pend_q.push_back(wf);
    if (fl) pend_q.delete();
    if ((m_fflags | cf) != m_fflags) m_dirty = 1'b1;
    m_fflags = m_fflags | cf;
    if (cw && sel[0]) m_fflags = data[4:0];
    if (cw && sel == 2'd2) m_frm = data[2:0];
    if (cw && sel == 2'd3) m_frm = data[7:5];
    if (cw && sel != 2'd0) m_dirty = 1'b1;
    e.fflags = m_fflags; e.frm = m_frm; e.ready = (pend_q.size() < depth); e.dirty = m_dirty;
    exp_q.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    e = exp_q.pop_front();
    check_eq({tag, ".fflags"}, 32'(fflags), 32'(e.fflags));
    check_eq({tag, ".frm"}, 32'(frm), 32'(e.frm));
    check_eq({tag, ".ready"}, 32'(wb_ready), 32'(e.ready));
    check_eq({tag, ".dirty"}, 32'(fs_dirty), 32'(e.dirty));
  endtask

  task automatic push(input logic [4:0] f, input string tag);
    step(1'b1, f, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, tag);
  endtask

  task automatic commit(input string tag);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, tag);
  endtask

  task automatic check_csr(input logic [1:0] sel, input string tag);
    logic [7:0] want;
    csr_sel = sel;
    #1;
    case (sel)
      2'd1:    want = {3'b000, m_fflags};
      2'd2:    want = {5'b00000, m_frm};
      2'd3:    want = {m_frm, m_fflags};
      default: want = 8'd0;
    endcase
    check_eq(tag, 32'(csr_rdata), 32'(want));
    csr_sel = 2'd0;
  endtask

  task automatic check_rm(input logic [2:0] irm, input logic [2:0] want_rm,
                          input logic want_ill, input string tag);
    instr_rm = irm;
    #1;
    check_eq({tag, ".rm"}, 32'(rm), 32'(want_rm));
    check_eq({tag, ".illegal"}, 32'(rm_illegal), 32'(want_ill));
    instr_rm = 3'd0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #21;
    apply_reset("rst0");
    check_csr(2'd3, "rst0.fcsr");

    // Committing all-zero flags must not mark state dirty.
    push(5'b00000, "zpush");
    commit("zcommit");
    check_eq("zcommit.dirty_const", 32'(fs_dirty), 32'd0);

    push(5'b00001, "t1.push");
    commit("t1.commit");
    check_eq("t1.fflags_const", 32'(fflags), 32'h01);
    check_eq("t1.dirty_const", 32'(fs_dirty), 32'd1);

    // Reset in the middle of operation drops queued entries.
    push(5'b10000, "mid.push0");
    push(5'b01000, "mid.push1");
    apply_reset("rst_mid");

    push(5'b10000, "t2.push0");
    push(5'b01000, "t2.push1");
    push(5'b00100, "t2.push2");
    push(5'b00010, "t2.push3");
    check_eq("t2.full_ready_const", 32'(wb_ready), 32'd0);
    commit("t2.commit0");
    commit("t2.commit1");
    check_eq("t2.fflags_const", 32'(fflags), 32'h18);
    check_eq("t2.ready_const", 32'(wb_ready), 32'd1);

    push(5'b00001, "t3.push");
    step(1'b1, 5'b00001, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, "t3.flush");
    check_eq("t3.fflags_const", 32'(fflags), 32'h1c);
    push(5'b00100, "t3.refill0");
    push(5'b00001, "t3.refill1");
    push(5'b00010, "t3.refill2");
    check_eq("t3.count3_ready_const", 32'(wb_ready), 32'd1);

    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 2'd3, 8'b011_00000, "t4.csr_commit");
    check_eq("t4.frm_const", 32'(frm), 32'd3);
    check_eq("t4.fflags_const", 32'(fflags), 32'd0);
    check_csr(2'd3, "t4.fcsr");

    step(1'b1, 5'b10000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, "t5.push_pop");
    check_eq("t5.fflags_const", 32'(fflags), 32'h01);

    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 2'd2, 8'b1110_0101, "t6.frm_commit");
    check_eq("t6.frm_const", 32'(frm), 32'd5);
    check_eq("t6.fflags_const", 32'(fflags), 32'h03);

    check_rm(3'b111, 3'b101, 1'b1, "rm.dyn5");
    check_rm(3'b001, 3'b001, 1'b0, "rm.static1");
    check_rm(3'b110, 3'b110, 1'b1, "rm.static6");
    check_rm(3'b100, 3'b100, 1'b0, "rm.static4");

    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'b1110_1010, "t7.fflags_wr");
    check_csr(2'd1, "t7.rd_fflags");
    check_csr(2'd2, "t7.rd_frm");
    check_csr(2'd3, "t7.rd_fcsr");
    check_csr(2'd0, "t7.rd_none");
    commit("t7.commit");
    check_eq("t7.fflags_const", 32'(fflags), 32'h1a);

    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 8'b0000_0010, "t8.frm_wr");
    check_rm(3'b111, 3'b010, 1'b0, "rm.dyn2");

`ifdef BP_BE_FFLAGS_BYPASS_EN
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd0, "t9.clear");
    step(1'b1, 5'b00010, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, "t9.bypass");
    check_eq("t9.fflags_const", 32'(fflags), 32'h02);
    push(5'b00001, "t9.push0");
    push(5'b00001, "t9.push1");
    push(5'b00001, "t9.push2");
    check_eq("t9.not_full_const", 32'(wb_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
